// File: rtl/calc_engine.sv
// ---------------------------------------------------------------------------
// calc_engine
//   Four-function-plus-logic calculator sequencer behind a hex keypad.
//   The keypad owns the entry register; this block latches operands from it,
//   runs the selected operation and shows the result on the visor.
//
// Ports
//   clk           in   system clock, rising edge
//   reset         in   synchronous, active-high reset
//   entry[39:0]   in   current keypad entry (10 hex digits, digit9 = [39:36])
//   enter         in   one-cycle pulse on any keypad press
//   op[2:0]       in   operation at the cursor: 0 none, 1 add, 2 sub, 3 mul,
//                      4 and, 5 or (6/7 behave as 0)
//   exe           in   execute key pulse (coincident with enter)
//   ce            in   clear key pulse (coincident with enter)
//   ext_ce        out  one-cycle request to clear the keypad entry register
//   display[39:0] out  visor value: R while showing a result, else entry
//   busy          out  high while a computation is running
//   result_valid  out  high while display holds a result
//   overflow      out  carry / borrow / product-overflow of the last result
//   state[1:0]    out  0 S_A, 1 S_B, 2 S_CALC, 3 S_SHOW
// ---------------------------------------------------------------------------
module calc_engine (
    input  logic        clk,
    input  logic        reset,
    input  logic [39:0] entry,
    input  logic        enter,
    input  logic [2:0]  op,
    input  logic        exe,
    input  logic        ce,
    output logic        ext_ce,
    output logic [39:0] display,
    output logic        busy,
    output logic        result_valid,
    output logic        overflow,
    output logic [1:0]  state
);

    localparam logic [1:0] S_A    = 2'd0;
    localparam logic [1:0] S_B    = 2'd1;
    localparam logic [1:0] S_CALC = 2'd2;
    localparam logic [1:0] S_SHOW = 2'd3;

    localparam logic [2:0] OP_NONE = 3'd0;
    localparam logic [2:0] OP_ADD  = 3'd1;
    localparam logic [2:0] OP_SUB  = 3'd2;
    localparam logic [2:0] OP_MUL  = 3'd3;
    localparam logic [2:0] OP_AND  = 3'd4;
    localparam logic [2:0] OP_OR   = 3'd5;

    localparam logic [5:0] MUL_LAST = 6'd39;

    logic [1:0]  state_q, state_d;
    logic [39:0] a_q, a_d;
    logic [39:0] b_q, b_d;
    logic [39:0] r_q, r_d;
    logic [2:0]  opc_q, opc_d;
    logic        ext_ce_q, ext_ce_d;
    logic        rv_q, rv_d;
    logic        ovf_q, ovf_d;

    // Multiplier datapath: product accumulator, left-shifting multiplicand,
    // right-shifting copy of B, and a bit counter.
    logic [79:0] prod_q, prod_d;
    logic [79:0] mcand_q, mcand_d;
    logic [39:0] mplier_q, mplier_d;
    logic [5:0]  cnt_q, cnt_d;

    // Codes 6 and 7 behave exactly like "no operation".
    logic [2:0]  op_eff;
    logic        op_valid;

    logic [40:0] sum_w;
    logic [40:0] diff_w;
    logic [79:0] prod_add_w;

    assign op_eff   = (op > OP_OR) ? OP_NONE : op;
    assign op_valid = (op_eff != OP_NONE);

    // Extra top bit of the 41-bit add is the carry out of bit 39; for the
    // subtract it goes high exactly when B > A.
    assign sum_w      = {1'b0, a_q} + {1'b0, b_q};
    assign diff_w     = {1'b0, a_q} - {1'b0, b_q};
    assign prod_add_w = prod_q + (mplier_q[0] ? mcand_q : 80'd0);

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        r_d      = r_q;
        opc_d    = opc_q;
        ext_ce_d = 1'b0;
        rv_d     = rv_q;
        ovf_d    = ovf_q;
        prod_d   = prod_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;

        case (state_q)
            S_A: begin
                // exe here is meaningless; only an operator key advances.
                if (enter && op_valid) begin
                    a_d      = entry;
                    opc_d    = op_eff;
                    ext_ce_d = ~ext_ce_q;
                    state_d  = S_B;
                end
            end

            S_B: begin
                if (exe) begin
                    b_d      = entry;
                    prod_d   = 80'd0;
                    mcand_d  = {40'd0, a_q};
                    mplier_d = entry;
                    cnt_d    = 6'd0;
                    state_d  = S_CALC;
                end else if (enter && op_valid) begin
                    // User changed their mind about the operator.
                    opc_d = op_eff;
                end
            end

            S_CALC: begin
                case (opc_q)
                    OP_ADD: begin
                        r_d   = sum_w[39:0];
                        ovf_d = sum_w[40];
                    end
                    OP_SUB: begin
                        r_d   = diff_w[39:0];
                        ovf_d = diff_w[40];
                    end
                    OP_AND: begin
                        r_d   = a_q & b_q;
                        ovf_d = 1'b0;
                    end
                    OP_OR: begin
                        r_d   = a_q | b_q;
                        ovf_d = 1'b0;
                    end
                    OP_MUL: begin
                        prod_d   = prod_add_w;
                        mcand_d  = {mcand_q[78:0], 1'b0};
                        mplier_d = {1'b0, mplier_q[39:1]};
                        cnt_d    = cnt_q + 6'd1;
                        // Bit 39 is folded in on the finishing edge, so the
                        // result comes straight from the adder output.
                        if (cnt_q == MUL_LAST) begin
                            r_d   = prod_add_w[39:0];
                            ovf_d = |prod_add_w[79:40];
                        end
                    end
                    default: begin
                        r_d   = 40'd0;
                        ovf_d = 1'b0;
                    end
                endcase

                if (opc_q != OP_MUL || cnt_q == MUL_LAST) begin
                    state_d  = S_SHOW;
                    rv_d     = 1'b1;
                    ext_ce_d = ~ext_ce_q;
                end
            end

            S_SHOW: begin
                if (enter && op_valid) begin
                    // Chained operation: the shown result becomes A.
                    a_d      = r_q;
                    opc_d    = op_eff;
                    ext_ce_d = ~ext_ce_q;
                    rv_d     = 1'b0;
                    state_d  = S_B;
                end else if (enter && !exe) begin
                    // Digit press starts a fresh calculation.
                    rv_d    = 1'b0;
                    state_d = S_A;
                end
            end

            default: state_d = S_A;
        endcase

        // Clear wins over everything; the keypad wipes itself on ce so no
        // ext_ce request is issued.
        if (ce) begin
            state_d  = S_A;
            a_d      = 40'd0;
            b_d      = 40'd0;
            r_d      = 40'd0;
            opc_d    = OP_NONE;
            ext_ce_d = 1'b0;
            rv_d     = 1'b0;
            ovf_d    = 1'b0;
            cnt_d    = 6'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_A;
            a_q      <= 40'd0;
            b_q      <= 40'd0;
            r_q      <= 40'd0;
            opc_q    <= OP_NONE;
            ext_ce_q <= 1'b0;
            rv_q     <= 1'b0;
            ovf_q    <= 1'b0;
            prod_q   <= 80'd0;
            mcand_q  <= 80'd0;
            mplier_q <= 40'd0;
            cnt_q    <= 6'd0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            r_q      <= r_d;
            opc_q    <= opc_d;
            ext_ce_q <= ext_ce_d;
            rv_q     <= rv_d;
            ovf_q    <= ovf_d;
            prod_q   <= prod_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    assign ext_ce       = ext_ce_q;
    assign display      = (state_q == S_SHOW) ? r_q : entry;
    assign busy         = (state_q == S_CALC);
    assign result_valid = rv_q;
    assign overflow     = ovf_q;
    assign state        = state_q;

endmodule

// File: tb/tb_calc_engine.sv
// Directed bench for calc_engine. Expected results are queued when exe is
// issued; a monitor pops and compares on each rising edge of result_valid.
module tb_calc_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic [39:0] entry;
    logic        enter;
    logic [2:0]  op;
    logic        exe;
    logic        ce;
    logic        ext_ce;
    logic [39:0] display;
    logic        busy;
    logic        result_valid;
    logic        overflow;
    logic [1:0]  state;

    typedef struct {
        logic [39:0] d;
        logic        o;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic rv_prev = 1'b0;

    always #5 clk = ~clk;

    calc_engine dut (
        .clk          (clk),
        .reset        (reset),
        .entry        (entry),
        .enter        (enter),
        .op           (op),
        .exe          (exe),
        .ce           (ce),
        .ext_ce       (ext_ce),
        .display      (display),
        .busy         (busy),
        .result_valid (result_valid),
        .overflow     (overflow),
        .state        (state)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic press(input logic [39:0] e, input logic [2:0] o, input logic x, input logic c);
        @(negedge clk);
        entry = e; op = o; exe = x; ce = c; enter = 1'b1;
        @(negedge clk);
        enter = 1'b0; exe = 1'b0; ce = 1'b0; op = 3'd0;
    endtask

    task automatic expect_res(input logic [39:0] d, input logic o);
        exp_t e;
        e.d = d;
        e.o = o;
        exp_q.push_back(e);
    endtask

    task automatic wait_show(input string name);
        int n = 0;
        while (state !== 2'd3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(name, {62'd0, state}, 64'd3);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        exp_t e;
        if (reset === 1'b0 && result_valid === 1'b1 && rv_prev === 1'b0) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got display 0x%0h with no result expected", display);
            end else begin
                e = exp_q.pop_front();
                chk("result_display", {24'd0, display}, {24'd0, e.d});
                chk("result_overflow", {63'd0, overflow}, {63'd0, e.o});
            end
        end
        rv_prev = result_valid;
    end

    initial begin
        int n;
        reset = 1'b1; entry = 40'hABCDE; enter = 1'b0; op = 3'd0; exe = 1'b0; ce = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_state", {62'd0, state}, 64'd0);
        chk("rst_flags", {60'd0, ext_ce, busy, result_valid, overflow}, 64'd0);
        chk("rst_display", {24'd0, display}, 64'hABCDE);
        reset = 1'b0;

        // Add 0x12 + 0x30
        press(40'h12, 3'd1, 1'b0, 1'b0);
        chk("add_ext_ce_A", {63'd0, ext_ce}, 64'd1);
        chk("add_state_B", {62'd0, state}, 64'd1);
        @(negedge clk);
        chk("add_ext_ce_single", {63'd0, ext_ce}, 64'd0);
        expect_res(40'h42, 1'b0);
        press(40'h30, 3'd0, 1'b1, 1'b0);
        chk("add_calc_busy", {62'd0, state, busy}, {61'd0, 3'b101});
        @(negedge clk);
        chk("add_show", {61'd0, state, result_valid}, {61'd0, 3'b111});
        chk("add_show_ext_ce", {63'd0, ext_ce}, 64'd1);

        // Chain: 0x42 & 0x0F
        press(40'h99, 3'd4, 1'b0, 1'b0);
        chk("chain_state_B", {62'd0, state}, 64'd1);
        chk("chain_rv_clear", {63'd0, result_valid}, 64'd0);
        chk("chain_ext_ce", {63'd0, ext_ce}, 64'd1);
        expect_res(40'h02, 1'b0);
        press(40'h0F, 3'd0, 1'b1, 1'b0);
        wait_show("chain_show");

        // Digit press leaves S_SHOW
        press(40'h5, 3'd0, 1'b0, 1'b0);
        chk("digit_state_A", {61'd0, state, result_valid}, 64'd0);
        chk("digit_display", {24'd0, display}, 64'h5);

        // Sub with borrow; overflow then holds in S_A
        press(40'h5, 3'd2, 1'b0, 1'b0);
        expect_res(40'hFFFFFFFFFE, 1'b1);
        press(40'h7, 3'd0, 1'b1, 1'b0);
        wait_show("sub_show");
        press(40'h0, 3'd0, 1'b0, 1'b0);
        chk("ovf_holds", {63'd0, overflow}, 64'd1);

        // exe in S_A is ignored
        press(40'h9, 3'd0, 1'b1, 1'b0);
        chk("exe_in_A", {61'd0, state, ext_ce}, 64'd0);

        // Mul with an op change in S_B (A stays 0x10000)
        press(40'h10000, 3'd1, 1'b0, 1'b0);
        press(40'h777, 3'd3, 1'b0, 1'b0);
        chk("opchange_state", {61'd0, state, ext_ce}, {61'd0, 3'b010});
        expect_res(40'h1230000, 1'b0);
        press(40'h123, 3'd0, 1'b1, 1'b0);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("mul_busy_cycles", n, 64'd40);
        chk("mul_show", {62'd0, state}, 64'd3);
        chk("mul_ext_ce", {63'd0, ext_ce}, 64'd1);

        // Mul with product overflow
        press(40'h0, 3'd0, 1'b0, 1'b0);
        press(40'h10_0000_0000, 3'd3, 1'b0, 1'b0);
        expect_res(40'h0, 1'b1);
        press(40'h10_0000_0000, 3'd0, 1'b1, 1'b0);
        wait_show("mul_ovf_show");

        // Abort mid-multiply with ce
        press(40'h0, 3'd0, 1'b0, 1'b0);
        press(40'h3, 3'd3, 1'b0, 1'b0);
        press(40'h5, 3'd0, 1'b1, 1'b0);
        repeat (9) @(negedge clk);
        chk("abort_busy_before", {63'd0, busy}, 64'd1);
        press(40'h0, 3'd0, 1'b0, 1'b1);
        chk("abort_state", {62'd0, state}, 64'd0);
        chk("abort_flags", {60'd0, busy, result_valid, ext_ce, overflow}, 64'd0);
        press(40'h5, 3'd0, 1'b1, 1'b0);
        chk("abort_exe_ignored", {61'd0, state, busy}, 64'd0);
        repeat (45) @(negedge clk);

        // Add with carry out of bit 39
        press(40'hFFFFFFFFFF, 3'd1, 1'b0, 1'b0);
        expect_res(40'h0, 1'b1);
        press(40'h1, 3'd0, 1'b1, 1'b0);
        wait_show("carry_show");

        // OR (op 7 digit press first to confirm 6/7 act as none)
        press(40'h3, 3'd7, 1'b0, 1'b0);
        chk("op7_is_digit", {62'd0, state}, 64'd0);
        press(40'hF0, 3'd5, 1'b0, 1'b0);
        expect_res(40'hFF, 1'b0);
        press(40'h0F, 3'd0, 1'b1, 1'b0);
        wait_show("or_show");

        // Reset while showing a result
        @(negedge clk);
        entry = 40'h1234;
        reset = 1'b1;
        @(negedge clk);
        chk("reset_show_state", {62'd0, state}, 64'd0);
        chk("reset_show_flags", {60'd0, ext_ce, busy, result_valid, overflow}, 64'd0);
        chk("reset_show_display", {24'd0, display}, 64'h1234);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        chk("scoreboard_empty", exp_q.size(), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
